// File: rtl/vec_stream_tx_16_20.sv
// Ping-pong vector buffer: the host fills one bank by address/data writes while
// the other bank streams out element 0 first over a valid/ready interface.
module vec_stream_tx_16_20 #(
   parameter int N     = 16,
   parameter int T     = 20,
   parameter int ADDRW = $clog2(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [T-1:0]        wr_data,
   input  logic [ADDRW-1:0]    wr_addr,
   input  logic                wr_en,
   input  logic                commit,
   output logic                commit_ready,
   output logic signed [T-1:0] m_data_out_x,
   output logic                m_valid_x,
   input  logic                m_ready_x,
   output logic [15:0]         vec_sent
);

   localparam logic [ADDRW:0]   N_EXT = (ADDRW + 1)'(N);
   localparam logic [ADDRW-1:0] LAST  = ADDRW'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       full_q, full_d;
   logic             wb_q, wb_d;
   logic             rb_q, rb_d;
   logic [ADDRW-1:0] idx_q, idx_d;
   logic [15:0]      vec_sent_q, vec_sent_d;
   logic [T-1:0]     mem_q [2][N];
   logic [T-1:0]     mem_d [2][N];

   logic wr_ok, cm_ok, hs, last_beat;

   always_comb begin
      commit_ready = !full_q[wb_q];
      m_valid_x    = (state_q == SEND);
      m_data_out_x = m_valid_x ? mem_q[rb_q][idx_q] : '0;
      vec_sent     = vec_sent_q;

      wr_ok     = wr_en && commit_ready && ({1'b0, wr_addr} < N_EXT);
      cm_ok     = commit && commit_ready;
      hs        = m_valid_x && m_ready_x;
      last_beat = hs && (idx_q == LAST);
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_ok) begin
         mem_d[wb_q][wr_addr] = wr_data;
      end
   end

   // A commit needs full[wb]==0 and a handshake needs full[rb]==1, so the two
   // never touch the same bank flag in one cycle.
   always_comb begin
      full_d     = full_q;
      wb_d       = wb_q;
      rb_d       = rb_q;
      idx_d      = idx_q;
      vec_sent_d = vec_sent_q;
      state_d    = state_q;

      if (cm_ok) begin
         full_d[wb_q] = 1'b1;
         wb_d         = ~wb_q;
      end

      if (hs) begin
         if (last_beat) begin
            idx_d        = '0;
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            vec_sent_d   = vec_sent_q + 16'd1;
         end else begin
            idx_d = idx_q + ADDRW'(1);
         end
      end

      // Looking at the post-edge flags lets the first beat appear right after
      // the commit edge and lets back-to-back vectors stream without a bubble.
      case (state_q)
         IDLE:    if (full_d[rb_d]) state_d = SEND;
         SEND:    if (last_beat) state_d = full_d[rb_d] ? SEND : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         full_q     <= '0;
         wb_q       <= 1'b0;
         rb_q       <= 1'b0;
         idx_q      <= '0;
         vec_sent_q <= '0;
      end else begin
         state_q    <= state_d;
         full_q     <= full_d;
         wb_q       <= wb_d;
         rb_q       <= rb_d;
         idx_q      <= idx_d;
         vec_sent_q <= vec_sent_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
